r_ptr_empty_ctrl: RTL and testbench

Read-side pointer and status controller for the dual-clock FIFO, the next generation of the read-pointer/empty block.
- Owns an internal SYNC_STAGES-deep synchronizer for the incoming write Gray pointer.
- Generates read address, Gray read pointer and registered empty.
- Adds almost-empty threshold, read-side fill level and underflow reporting.
- Sits in the read clock domain between the FIFO memory read port and the consumer.

---
 rtl/r_ptr_empty_ctrl_if.sv | 30 +++
 rtl/r_ptr_empty_ctrl.sv | 80 ++++++++
 tb/tb_r_ptr_empty_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/r_ptr_empty_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | r_ptr_empty_ctrl_if : read-side FIFO control bundle                   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface r_ptr_empty_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH:0]   w_ptr_gray;
  logic                  r_inc;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_underflow;

  // consumer / write-pointer source side
  modport master (
    output w_ptr_gray, r_inc,
    input  r_addr, r_ptr, r_empty, r_almost_empty, r_count, r_underflow
  );

  // controller side
  modport slave (
    input  w_ptr_gray, r_inc,
    output r_addr, r_ptr, r_empty, r_almost_empty, r_count, r_underflow
  );
endinterface
`default_nettype wire

// File: rtl/r_ptr_empty_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | r_ptr_empty_ctrl : read pointer, empty/almost-empty, fill, underflow  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module r_ptr_empty_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                  r_clk,
  input  logic                  r_reset,
  r_ptr_empty_ctrl_if.slave     bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_param
    $error("r_ptr_empty_ctrl: illegal SYNC_STAGES or AE_THRESH");
  end

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] rq_wptr;
  logic [PW-1:0] wbin;
  logic [PW-1:0] bin_q;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] count_next;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] count_q;
  logic          empty_q;
  logic          ae_q;
  logic          under_q;
  logic          rd_en;

  assign rq_wptr    = sync_q[SYNC_STAGES-1];
  assign rd_en      = bus.r_inc & ~empty_q;
  assign bin_next   = bin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign gray_next  = bin_next ^ (bin_next >> 1);
  assign count_next = wbin - bin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(rq_wptr >> i);
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_reset) begin
      sync_q  <= '0;
      bin_q   <= '0;
      ptr_q   <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      count_q <= '0;
      under_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.w_ptr_gray};
      bin_q   <= bin_next;
      ptr_q   <= gray_next;
      empty_q <= (gray_next == rq_wptr);
      ae_q    <= (count_next <= AE_LIM);
      count_q <= count_next;
      under_q <= bus.r_inc & empty_q;
    end
  end

  assign bus.r_addr         = bin_q[ADDR_WIDTH-1:0];
  assign bus.r_ptr          = ptr_q;
  assign bus.r_empty        = empty_q;
  assign bus.r_almost_empty = ae_q;
  assign bus.r_count        = count_q;
  assign bus.r_underflow    = under_q;

endmodule
`default_nettype wire

// File: tb/tb_r_ptr_empty_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_r_ptr_empty_ctrl : randomized/directed bench with count-level model|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_r_ptr_empty_ctrl;
  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  r_ptr_empty_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  r_ptr_empty_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .r_clk   (clk),
    .r_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: total words written/read as integers, synchronizer as a delay line
  int   m_wr = 0;
  int   m_rd = 0;
  int   m_fill = 0;
  int   m_q[$];
  logic m_empty = 1'b1;
  logic m_ae = 1'b1;
  logic m_under = 1'b0;

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v % MOD);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int used;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < SS; i++) m_q.push_back(0);
      m_rd = 0; m_fill = 0; m_empty = 1'b1; m_ae = 1'b1; m_under = 1'b0;
    end else begin
      used = m_q.pop_front();
      m_q.push_back(m_wr);
      m_under = bus.r_inc && m_empty;
      if (bus.r_inc && !m_empty) m_rd = (m_rd + 1) % MOD;
      m_fill  = ((used - m_rd) % MOD + MOD) % MOD;
      m_empty = (m_fill == 0);
      m_ae    = (m_fill <= AE);
    end
  endtask

  task automatic compare();
    chk("empty",        32'(bus.r_empty),        32'(m_empty));
    chk("almost_empty", 32'(bus.r_almost_empty), 32'(m_ae));
    chk("count",        32'(bus.r_count),        32'(m_fill));
    chk("underflow",    32'(bus.r_underflow),    32'(m_under));
    chk("addr",         32'(bus.r_addr),         32'(m_rd % DEPTH));
    chk("ptr",          32'(bus.r_ptr),          32'(gray(m_rd)));
    chk("count_le_depth", 32'(bus.r_count <= DEPTH), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_wr(input int v);
    m_wr = v % MOD;
    bus.w_ptr_gray = gray(m_wr);
  endtask

  function automatic int pending();
    return ((m_wr - m_rd) % MOD + MOD) % MOD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with read request and nonzero write pointer pending
    rst = 1'b1;
    bus.r_inc = 1'b1;
    bus.w_ptr_gray = 5'b00011;
    repeat (3) begin
      step();
      chk("rst_empty", 32'(bus.r_empty), 32'd1);
      chk("rst_count", 32'(bus.r_count), 32'd0);
    end
    rst = 1'b0;
    bus.r_inc = 1'b0;
    set_wr(0);
    step();

    // single write: visible exactly SS+1 edges later
    set_wr(1);
    repeat (SS) begin
      step();
      chk("sw_still_empty", 32'(bus.r_empty), 32'd1);
    end
    step();
    chk("sw_empty_fall", 32'(bus.r_empty), 32'd0);
    chk("sw_count1", 32'(bus.r_count), 32'd1);
    bus.r_inc = 1'b1;
    step();
    bus.r_inc = 1'b0;
    chk("sw_addr1", 32'(bus.r_addr), 32'd1);
    chk("sw_ptr1", 32'(bus.r_ptr), 32'd1);
    chk("sw_empty_rise", 32'(bus.r_empty), 32'd1);

    // underflow for two cycles
    bus.r_inc = 1'b1;
    repeat (2) begin
      step();
      chk("uf_pulse", 32'(bus.r_underflow), 32'd1);
      chk("uf_addr_hold", 32'(bus.r_addr), 32'd1);
    end
    bus.r_inc = 1'b0;
    step();

    // fill to DEPTH, then drain
    while (pending() < DEPTH) begin
      set_wr(m_wr + 1);
      step();
    end
    repeat (SS + 1) step();
    chk("fill_count16", 32'(bus.r_count), 32'(DEPTH));
    chk("fill_ae_low", 32'(bus.r_almost_empty), 32'd0);
    bus.r_inc = 1'b1;
    repeat (DEPTH + 2) step();
    bus.r_inc = 1'b0;
    chk("drain_empty", 32'(bus.r_empty), 32'd1);

    // wrap-around with paired writes and reads
    set_wr(m_wr + 3);
    repeat (SS + 2) step();
    bus.r_inc = 1'b1;
    repeat (40) begin
      set_wr(m_wr + 1);
      step();
      chk("wrap_no_uf", 32'(bus.r_underflow), 32'd0);
    end
    repeat (6) step();
    bus.r_inc = 1'b0;
    step();

    // mid-operation reset at count 7
    repeat (7) begin
      set_wr(m_wr + 1);
      step();
    end
    repeat (SS + 1) step();
    chk("mr_count7", 32'(bus.r_count), 32'd7);
    rst = 1'b1;
    set_wr(0);
    step();
    chk("mr_empty", 32'(bus.r_empty), 32'd1);
    chk("mr_count0", 32'(bus.r_count), 32'd0);
    chk("mr_addr0", 32'(bus.r_addr), 32'd0);
    rst = 1'b0;
    repeat (5) begin
      set_wr(m_wr + 1);
      step();
    end
    repeat (SS + 1) step();
    chk("mr_resume5", 32'(bus.r_count), 32'd5);

    // randomized traffic
    repeat (500) begin
      bus.r_inc = 1'($urandom_range(0, 1));
      if (pending() < DEPTH && $urandom_range(0, 2) != 0) set_wr(m_wr + 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
